// File: rtl/branch_predictor_if.sv
// Fetch/execute connection bundle for branch_predictor.
// The BP_GSHARE_EN macro adds the pred_ghr and ex_ghr history signals.
interface branch_predictor_if #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
);
  logic             f_valid;
  logic             f_stall;
  logic [31:0]      f_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic             ex_valid;
  logic [6:0]       ex_opcode;
  logic [31:0]      ex_pc;
  logic             ex_taken;
  logic             ex_pred_taken;
  logic             mispredict;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;
`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] pred_ghr;
  logic [IDX_W-1:0] ex_ghr;
`endif

  // The pipeline drives master. The predictor is the slave.
  modport master (
    output f_valid, f_stall, f_pc, ex_valid, ex_opcode, ex_pc, ex_taken, ex_pred_taken,
`ifdef BP_GSHARE_EN
    output ex_ghr,
    input  pred_ghr,
`endif
    input  pred_valid, pred_taken, mispredict, stat_branches, stat_mispredicts
  );

  modport slave (
    input  f_valid, f_stall, f_pc, ex_valid, ex_opcode, ex_pc, ex_taken, ex_pred_taken,
`ifdef BP_GSHARE_EN
    input  ex_ghr,
    output pred_ghr,
`endif
    output pred_valid, pred_taken, mispredict, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-side 2-bit saturating-counter direction predictor, trained by resolved execute branches.
// Defining BP_GSHARE_EN switches to gshare indexing (PC index XOR global history).
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 32
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);
  localparam int         IDX_W     = $clog2(ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic             upd;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic [ENTRIES-1:0] ctr_msb;

  logic             pred_valid_reg;
  logic             pred_taken_reg;
  logic             mispredict_reg;
  logic [CNT_W-1:0] stat_branches_reg;
  logic [CNT_W-1:0] stat_mispredicts_reg;

  assign upd = bus.ex_valid && (bus.ex_opcode == OP_BRANCH);

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_reg;
  logic [IDX_W-1:0] pred_ghr_reg;

  assign lookup_idx = bus.f_pc[IDX_W+1:2] ^ ghr_reg;
  assign update_idx = bus.ex_pc[IDX_W+1:2] ^ bus.ex_ghr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_reg <= '0;
    end else if (upd) begin
      ghr_reg <= {ghr_reg[IDX_W-2:0], bus.ex_taken};
    end
  end

  // The history snapshot follows pred_taken so execute can train the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_ghr_reg <= '0;
    end else if (!bus.f_stall) begin
      pred_ghr_reg <= bus.f_valid ? ghr_reg : '0;
    end
  end

  assign bus.pred_ghr = pred_ghr_reg;
`else
  assign lookup_idx = bus.f_pc[IDX_W+1:2];
  assign update_idx = bus.ex_pc[IDX_W+1:2];
`endif

  // One saturating counter per entry. Only bit[1] is needed on the read side.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
      logic [1:0] ctr_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          ctr_reg <= 2'b01;
        end else if (upd && (update_idx == IDX_W'(gi))) begin
          if (bus.ex_taken && (ctr_reg != 2'b11)) begin
            ctr_reg <= ctr_reg + 2'd1;
          end else if (!bus.ex_taken && (ctr_reg != 2'b00)) begin
            ctr_reg <= ctr_reg - 2'd1;
          end
        end
      end

      assign ctr_msb[gi] = ctr_reg[1];
    end
  endgenerate

  // The read samples the pre-edge counter, so a same-edge update is not visible yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_reg <= 1'b0;
      pred_taken_reg <= 1'b0;
    end else if (!bus.f_stall) begin
      pred_valid_reg <= bus.f_valid;
      pred_taken_reg <= bus.f_valid && ctr_msb[lookup_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_reg       <= 1'b0;
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      mispredict_reg <= upd && (bus.ex_taken != bus.ex_pred_taken);
      if (upd && (stat_branches_reg != '1)) begin
        stat_branches_reg <= stat_branches_reg + 1'b1;
      end
      if (upd && (bus.ex_taken != bus.ex_pred_taken) && (stat_mispredicts_reg != '1)) begin
        stat_mispredicts_reg <= stat_mispredicts_reg + 1'b1;
      end
    end
  end

  assign bus.pred_valid       = pred_valid_reg;
  assign bus.pred_taken       = pred_taken_reg;
  assign bus.mispredict       = mispredict_reg;
  assign bus.stat_branches    = stat_branches_reg;
  assign bus.stat_mispredicts = stat_mispredicts_reg;
endmodule
